// File: rtl/led_show_pkg.sv
// Shared types and pure helpers for the LED show sequencer: mode/state encodings,
// pattern decode and the forward search for the next slot that actually runs.
package led_show_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      BLINK = 2'd2,
      SKIP  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_e;

   typedef struct packed {
      logic       vld;
      logic [1:0] idx;
   } slot_sel_t;

   function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [1:0] phase);
      case (mode_e'(mode))
         FILL:    pattern = 4'b1111 >> (2'd3 - phase);
         DRAIN:   pattern = 4'b0111 >> phase;
         BLINK:   pattern = phase[0] ? 4'b0000 : 4'b1111;
         default: pattern = 4'b0000;
      endcase
   endfunction

   // Lowest non-SKIP slot with index >= from; from = 4 means nothing is left.
   function automatic slot_sel_t next_slot(input logic [7:0] prog, input logic [2:0] from);
      slot_sel_t s;
      s = '0;
      for (int k = 3; k >= 0; k--) begin
         if (k >= int'(from) && mode_e'(prog[2*k +: 2]) != SKIP) begin
            s.vld = 1'b1;
            s.idx = 2'(k);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/led_show_ctrl_if.sv
// Control/status bundle between the lab top level and the LED show sequencer.
interface led_show_ctrl_if;
   logic       start;
   logic       stop;
   logic       pause;
   logic [7:0] prog;
   logic [1:0] rep;
   logic [3:0] light;
   logic       busy;
   logic       done;

   modport master (output start, stop, pause, prog, rep, input light, busy, done);
   modport slave  (input start, stop, pause, prog, rep, output light, busy, done);
endinterface

// File: rtl/sec_tick.sv
// Step prescaler: tick is high combinationally in the last enabled cycle of each
// TICK_CYCLES period; en low freezes the count, clr restarts it from zero.
module sec_tick #(
   parameter int TICK_CYCLES = 100_000_000,
   parameter int CNT_W       = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CNT_W'(TICK_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/led_show_ctrl.sv
// LED show sequencer: snapshots a 4-slot program at start and steps each slot's
// pattern once per tick; light decodes from registered state, done is registered.
module led_show_ctrl
   import led_show_pkg::*;
#(
   parameter int TICK_CYCLES = 100_000_000,
   parameter int CNT_W       = 32
) (
   input  logic           clk,
   input  logic           rst,
   led_show_ctrl_if.slave bus
);
   state_e     state_q, state_d;
   logic [7:0] prog_q, prog_d;
   logic [1:0] rep_q, rep_d;
   logic [1:0] phase_q, phase_d;
   logic [1:0] rep_cnt_q, rep_cnt_d;
   logic [1:0] slot_q, slot_d;
   logic       done_q, done_d;
   logic       tick, tick_en, tick_clr;
   slot_sel_t  sel;

   assign tick_en = (state_q == RUN);

   sec_tick #(.TICK_CYCLES(TICK_CYCLES), .CNT_W(CNT_W)) u_sec_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         prog_q    <= '0;
         rep_q     <= '0;
         phase_q   <= '0;
         rep_cnt_q <= '0;
         slot_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prog_q    <= prog_d;
         rep_q     <= rep_d;
         phase_q   <= phase_d;
         rep_cnt_q <= rep_cnt_d;
         slot_q    <= slot_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      prog_d    = prog_q;
      rep_d     = rep_q;
      phase_d   = phase_q;
      rep_cnt_d = rep_cnt_q;
      slot_d    = slot_q;
      done_d    = 1'b0;
      tick_clr  = 1'b0;
      sel       = '0;
      case (state_q)
         IDLE: begin
            // stop outranks start even though stop alone does nothing here
            if (bus.start && !bus.stop) begin
               prog_d    = bus.prog;
               rep_d     = bus.rep;
               phase_d   = '0;
               rep_cnt_d = '0;
               tick_clr  = 1'b1;
               sel       = next_slot(bus.prog, 3'd0);
               if (sel.vld) begin
                  slot_d  = sel.idx;
                  state_d = RUN;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         RUN, PAUSED: begin
            if (bus.stop) begin
               state_d  = IDLE;
               tick_clr = 1'b1;
            end else if (state_q == RUN) begin
               if (tick) begin
                  phase_d = phase_q + 2'd1;
                  if (phase_q == 2'd3) begin
                     if (rep_cnt_q == rep_q) begin
                        rep_cnt_d = '0;
                        sel       = next_slot(prog_q, {1'b0, slot_q} + 3'd1);
                        if (sel.vld) begin
                           slot_d  = sel.idx;
                        end else begin
                           state_d = IDLE;
                           done_d  = 1'b1;
                        end
                     end else begin
                        rep_cnt_d = rep_cnt_q + 2'd1;
                     end
                  end
               end
               if (state_d == RUN && bus.pause)
                  state_d = PAUSED;
            end else if (!bus.pause) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state_q != IDLE);
      bus.done  = done_q;
      bus.light = (state_q != IDLE) ? pattern(prog_q[2*slot_q +: 2], phase_q) : 4'b0000;
   end
endmodule

// File: tb/tb_led_show_ctrl.sv
// Bench for led_show_ctrl with a short tick: per-cycle expected light sequence
// built from the mode tables, plus a pause/run bookkeeping model.
module tb_led_show_ctrl;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   led_show_ctrl_if bus_if();

   led_show_ctrl #(.TICK_CYCLES(T), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ref_pat(input int m, input int ph);
      case (m)
         0:       return 4'((1 << (ph + 1)) - 1);
         1:       return 4'(15 >> (ph + 1));
         2:       return (ph % 2 == 0) ? 4'hF : 4'h0;
         default: return 4'h0;
      endcase
   endfunction

   // pause is high at edge e (start edge = 0) iff pause_at <= e < pause_at+pause_len;
   // stop is pulsed at edge stop_at. walls returns edges from start to done.
   task automatic run_show(input logic [7:0] p, input logic [1:0] rp, input int pause_at,
                           input int pause_len, input int stop_at, input string name,
                           output int walls);
      logic [3:0] exp_q[$];
      logic [5:0] got, want;
      int  r, wall;
      bit  paused, stopped, pz;
      exp_q = {};
      for (int k = 0; k < 4; k++)
         if (p[2*k +: 2] != 2'd3)
            for (int n = 0; n <= int'(rp); n++)
               for (int ph = 0; ph < 4; ph++)
                  for (int t = 0; t < T; t++)
                     exp_q.push_back(ref_pat(int'(p[2*k +: 2]), ph));

      bus_if.prog  = p;
      bus_if.rep   = rp;
      bus_if.start = 1'b1;
      bus_if.pause = (pause_at == 0 && pause_len > 0);
      step();
      bus_if.start = 1'b0;
      bus_if.prog  = 8'($urandom);
      bus_if.rep   = 2'($urandom);
      r = 0; wall = 0; paused = 0; walls = 0;

      if (exp_q.size() == 0) begin
         bus_if.pause = 1'b0;
         got = {bus_if.busy, bus_if.done, bus_if.light}; want = 6'b010000; n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s skip_done {busy,done,light} got %b want %b", name, got, want);
         end
         step();
         got = {bus_if.busy, bus_if.done, bus_if.light}; want = 6'b000000; n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s skip_after {busy,done,light} got %b want %b", name, got, want);
         end
         return;
      end

      while (r < exp_q.size() && wall < 2000) begin
         got = {bus_if.busy, bus_if.done, bus_if.light}; want = {2'b10, exp_q[r]}; n_cmp++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d run=%0d {busy,done,light} got %b want %b",
                     name, wall, r, got, want);
         end
         pz = (pause_at >= 0 && wall + 1 >= pause_at && wall + 1 < pause_at + pause_len);
         stopped = (wall + 1 == stop_at);
         bus_if.pause = pz;
         bus_if.stop  = stopped;
         bus_if.start = ($urandom_range(0, 7) == 0);
         step();
         bus_if.stop  = 1'b0;
         bus_if.start = 1'b0;
         wall++;
         if (stopped) begin
            bus_if.pause = 1'b0;
            for (int i = 0; i < 3; i++) begin
               got = {bus_if.busy, bus_if.done, bus_if.light}; want = 6'b000000; n_cmp++;
               if (got !== want) begin
                  n_fail++;
                  $display("FAIL %s after_stop+%0d {busy,done,light} got %b want %b",
                           name, i, got, want);
               end
               step();
            end
            walls = wall;
            return;
         end
         if (!paused) r++;
         paused = pz;
      end

      bus_if.pause = 1'b0;
      walls = wall;
      n_cmp++;
      if (wall >= 2000) begin
         n_fail++;
         $display("FAIL %s timeout run=%0d want %0d", name, r, exp_q.size());
         return;
      end
      got = {bus_if.busy, bus_if.done, bus_if.light}; want = 6'b010000;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s end_edge {busy,done,light} got %b want %b", name, got, want);
      end
      step();
      got = {bus_if.busy, bus_if.done, bus_if.light}; want = 6'b000000; n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s after_end {busy,done,light} got %b want %b", name, got, want);
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      #1;
      got = {bus_if.busy, bus_if.done, bus_if.light}; n_cmp++;
      if (got !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_state {busy,done,light} got %b want 000000", got);
      end
      step(); step();
      rst = 1'b0;
      step();
      bus_if.stop = 1'b1;
      step();
      bus_if.stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         got = {bus_if.busy, bus_if.done, bus_if.light}; n_cmp++;
         if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_stop+%0d {busy,done,light} got %b want 000000", i, got);
         end
         step();
      end
   endtask

   task automatic test_basic();
      int w;
      run_show(8'b11_10_01_00, 2'd0, -1, 0, -1, "basic", w);
      n_cmp++;
      if (w !== 48) begin
         n_fail++;
         $display("FAIL basic_len got %0d want 48", w);
      end
   endtask

   task automatic test_all_skip();
      int w;
      run_show(8'hFF, 2'd2, -1, 0, -1, "all_skip", w);
   endtask

   task automatic test_pause();
      int w;
      run_show(8'b11_11_11_00, 2'd1, 6, 10, -1, "pause", w);
      n_cmp++;
      if (w !== 42) begin
         n_fail++;
         $display("FAIL pause_len got %0d want 42", w);
      end
      run_show(8'b01_11_10_11, 2'd0, 0, 6, -1, "pause_at_start", w);
   endtask

   task automatic test_stop();
      int w;
      run_show(8'b11_10_01_00, 2'd0, -1, 0, 20, "stop", w);
      run_show(8'b11_10_01_00, 2'd0, -1, 0, -1, "restart", w);
   endtask

   task automatic test_async_reset();
      logic [5:0] got;
      int w;
      bus_if.prog = 8'h00; bus_if.rep = 2'd3; bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      #2 rst = 1'b1;
      #1;
      got = {bus_if.busy, bus_if.done, bus_if.light}; n_cmp++;
      if (got !== 6'b0) begin
         n_fail++;
         $display("FAIL async_rst {busy,done,light} got %b want 000000", got);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         got = {bus_if.busy, bus_if.done, bus_if.light}; n_cmp++;
         if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL post_rst+%0d {busy,done,light} got %b want 000000", i, got);
         end
      end
      run_show(8'b11_11_01_11, 2'd1, -1, 0, -1, "after_rst", w);
   endtask

   task automatic test_random();
      int w, pa, pl;
      for (int n = 0; n < 8; n++) begin
         pa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30));
         pl = int'($urandom_range(1, 12));
         run_show(8'($urandom), 2'($urandom), pa, pl, -1, "random", w);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_if.start = 1'b0;
      bus_if.stop  = 1'b0;
      bus_if.pause = 1'b0;
      bus_if.prog  = 8'h00;
      bus_if.rep   = 2'd0;
      test_reset();
      test_basic();
      test_all_skip();
      test_pause();
      test_stop();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/led_show_ctrl.md
# led_show_ctrl

Sequencer that drives the 4-LED light bank through a short, user-programmed show of fill, drain and blink patterns. It snapshots a 4-slot program at `start`, generates its own 1-second step tick, and steps each slot's pattern a programmed number of times. It supports pause, stop and end-of-show signalling. It replaces free-running pattern logic as the single owner of `light` in the lab top level.

## Interface
Parameters:
- `TICK_CYCLES`, 100_000_000: clock cycles per pattern step (1 s at 100 MHz); must be ≥ 2.
- `CNT_W`, 32: prescaler width; must hold `TICK_CYCLES-1`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins a show when idle.
- `stop` in 1: one-cycle pulse; aborts the show.
- `pause` in 1: level; freezes the show while high.
- `prog` in 8: four 2-bit mode codes; slot *k* = `prog[2k+1:2k]`; slot 0 runs first.
- `rep` in 2: repeats per slot, encoded as `rep+1` (1..4).
- `light` out 4: LED pattern.
- `busy` out 1: high in RUN or PAUSED.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- Mode codes:
  - FILL = 0: patterns 0001, 0011, 0111, 1111.
  - DRAIN = 1: patterns 0111, 0011, 0001, 0000.
  - BLINK = 2: patterns 1111, 0000, 1111, 0000.
  - SKIP = 3: slot consumes no time.
- States:
  - IDLE: `light` = 0000, `busy` = 0.
  - RUN: prescaler counts.
  - PAUSED: all counters frozen, `light` holds.
- Registers:
  - prescaler `cnt` (0..`TICK_CYCLES-1`).
  - `phase` (0..3).
  - `rep_cnt` (0..3).
  - `slot` (0..3).
  - snapshots `prog_q`, `rep_q`.
- IDLE, on `start`:
  - Load `prog_q`/`rep_q`; clear `cnt`, `phase`, `rep_cnt`.
  - Set `slot` to the first non-SKIP slot and go to RUN.
  - If all four slots are SKIP, stay in IDLE and pulse `done` next cycle.
- RUN:
  - Step tick occurs when `cnt == TICK_CYCLES-1`; then `cnt` returns to 0.
  - On tick, `phase` increments.
  - When `phase` wraps 3→0, `rep_cnt` increments.
  - When `rep_cnt == rep_q` at that wrap, advance to the next non-SKIP slot with a higher index and clear `rep_cnt`.
  - If there is no such slot, go to IDLE and pulse `done`.
- `light` = pattern(`prog_q[slot]`, `phase`) in RUN and PAUSED; 0000 otherwise. It is decoded combinationally from registered state.
- RUN → PAUSED when `pause` = 1; PAUSED → RUN when `pause` = 0. No tick is lost or duplicated.
- `stop` in RUN or PAUSED → IDLE next edge: `light` = 0000, no `done`.
- Priority: `stop` > `start` > `pause`. `start` is ignored while `busy`. `stop` in IDLE has no effect.
- `prog`/`rep` changes during a show have no effect.
- Reset values: state IDLE, all counters and snapshots 0, `light` = 0000, `busy` = 0, `done` = 0.
- Reset mid-show aborts immediately (asynchronous), with no `done`.

## Timing
- `start` sampled at edge N → `busy` = 1 and first pattern on `light` from edge N.
- Each pattern is held for exactly `TICK_CYCLES` RUN cycles; PAUSED cycles add to wall time only.
- Show length = 4·(`rep`+1)·`TICK_CYCLES`·(number of non-SKIP slots) RUN cycles.
- At the final tick edge, `busy` falls, `light` returns to 0000 and `done` rises for one cycle, all at the same edge.
- `pause` rising at edge M freezes `cnt` at its edge-M value; resume continues from it.
- `start` with `pause` already high: RUN for one cycle (`cnt` = 1), then PAUSED.
- `stop` and final tick in the same cycle: `stop` wins, no `done`.

## Structure
- Package `led_show_pkg`:
  - mode constants FILL/DRAIN/BLINK/SKIP.
  - state encoding IDLE/RUN/PAUSED.
  - function `pattern(mode, phase)` returning 4 bits.
  - function `next_slot(prog, from)` returning valid flag + index.
- Sub-module `sec_tick`: prescaler with `en` and `clr` inputs and `tick` output; parameters `TICK_CYCLES`, `CNT_W`.
- Everything else (FSM, phase/rep/slot counters, snapshot) lives in `led_show_ctrl`.

## Test plan
All scenarios use `TICK_CYCLES` = 4.
- Reset then idle: `light` = 0000, `busy` = 0, `done` = 0; `stop` has no effect.
- `prog` = 8'b11_10_01_00, `rep` = 0, pulse `start`:
  - `light` steps 0001, 0011, 0111, 1111, then 0111, 0011, 0001, 0000, then 1111, 0000, 1111, 0000, each held 4 cycles.
  - `done` pulses at cycle 48; `busy` high for 48 cycles.
- `prog` = 8'hFF, `start` → `busy` stays 0 and `done` pulses once on the next cycle.
- `prog` = 8'b11_11_11_00, `rep` = 1; raise `pause` for 10 cycles mid-pattern 0011:
  - `light` frozen for the pause.
  - Sequence FILL×2 completes after 32 RUN cycles (42 total).
- `stop` during the second slot → `light` = 0000 and `busy` = 0 next cycle, no `done`; a second `start` restarts from slot 0.
- Assert `rst` mid-show, asynchronously, between edges → outputs 0 immediately; `start` asserted during `busy` is ignored.
